// File: rtl/bf_sweep_pkg.sv
// Shared types and helpers for the Boolean-function truth-table sweep generator.
// Holds the sweep FSM state enum and the binary-to-Gray conversion.
package bf_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int HOLD_CNT_W = 8;

  function automatic logic [7:0] to_gray(input logic [7:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/bf_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD-1 while enabled, wrapping on last.
// The last output flags the final cycle of the hold window.
module bf_hold_timer
  import bf_sweep_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [HOLD_CNT_W-1:0] r_cnt;

  assign last = (r_cnt == HOLD_CNT_W'(HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= last ? '0 : r_cnt + HOLD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/bf_sweep_gen.sv
// Sweeps all 2**N_IN input vectors, holds each HOLD cycles and captures the truth table.
// Define BF_SWEEP_GRAY_EN to sweep in Gray order instead of binary order.
module bf_sweep_gen
  import bf_sweep_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  dut_out,
  output logic [N_IN-1:0]       vec_out,
  output logic                  vec_valid,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<N_IN)-1:0]  table_out
);

  localparam int TBL_W = 1 << N_IN;
  localparam logic [N_IN:0] IDX_LAST = (N_IN + 1)'(TBL_W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [N_IN:0]    r_idx;
  logic [TBL_W-1:0] r_table;
  logic [N_IN-1:0]  w_seq_vec;
  logic             w_run;
  logic             w_last;
  logic             w_step;

  assign w_run  = (r_state == RUN);
  assign w_step = w_run && w_last && !abort;

`ifdef BF_SWEEP_GRAY_EN
  assign w_seq_vec = N_IN'(to_gray(8'(r_idx[N_IN-1:0])));
`else
  assign w_seq_vec = r_idx[N_IN-1:0];
`endif

  bf_hold_timer #(
    .HOLD(HOLD)
  ) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (!w_run || abort),
    .en  (w_run),
    .last(w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        // abort wins over the terminal capture on the same edge
        if (abort) begin
          w_next = IDLE;
        end else if (w_last && (r_idx == IDX_LAST)) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    vec_out   = '0;
    vec_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      RUN: begin
        vec_out   = w_seq_vec;
        vec_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Index is one bit wider than the vector so the terminal compare never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_table <= '0;
    end else begin
      if (!w_run || abort) begin
        r_idx <= '0;
      end else if (w_last) begin
        r_idx <= r_idx + (N_IN + 1)'(1);
      end
      if ((r_state == IDLE) && start) begin
        r_table <= '0;
      end else if (w_step) begin
        r_table[w_seq_vec] <= dut_out;
      end
    end
  end

  assign table_out = r_table;

endmodule

// File: tb/tb_bf_sweep_gen.sv
// Directed bench for bf_sweep_gen: three instances cover HOLD=4, HOLD=1 and N_IN=8.
// Expected vectors, edges and truth tables are hand-derived constants.
module tb_bf_sweep_gen;

  logic clk = 1'b0;
  logic rst;

  logic       start3, abort3, dout3, sel_maj;
  logic [2:0] vec3;
  logic       vld3, busy3, done3;
  logic [7:0] tbl3;

  logic       start1, abort1, dout1;
  logic [2:0] vec1;
  logic       vld1, busy1, done1;
  logic [7:0] tbl1;

  logic         start8, abort8, dout8;
  logic [7:0]   vec8;
  logic         vld8, busy8, done8;
  logic [255:0] tbl8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dout3 = sel_maj ? ((vec3[0] & vec3[1]) | (vec3[0] & vec3[2]) | (vec3[1] & vec3[2]))
                         : ^vec3;
  assign dout1 = ^vec1;
  assign dout8 = 1'b1;

  bf_sweep_gen #(.N_IN(3), .HOLD(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .dut_out(dout3),
    .vec_out(vec3), .vec_valid(vld3), .busy(busy3), .done(done3), .table_out(tbl3)
  );

  bf_sweep_gen #(.N_IN(3), .HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_out(dout1),
    .vec_out(vec1), .vec_valid(vld1), .busy(busy1), .done(done1), .table_out(tbl1)
  );

  bf_sweep_gen #(.N_IN(8), .HOLD(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .dut_out(dout8),
    .vec_out(vec8), .vec_valid(vld8), .busy(busy8), .done(done8), .table_out(tbl8)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] seqv(input int i);
    logic [7:0] b;
    b = 8'(i);
`ifdef BF_SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  initial begin
    int ndone;
    logic [2:0] prev;

    rst = 1'b1;
    start3 = 0; abort3 = 0; sel_maj = 0;
    start1 = 0; abort1 = 0;
    start8 = 0; abort8 = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", busy3, 0);
    chk("rst_vld", vld3, 0);
    chk("rst_done", done3, 0);
    chk("rst_vec", vec3, 0);
    chk("rst_tbl", tbl3, 0);

    // Abort mid-sweep: XOR function, abort sampled at edge 11
    sel_maj = 0;
    start3 = 1; tick(); start3 = 0;           // edge 0
    chk("ab_busy0", busy3, 1);
    for (int e = 1; e <= 10; e++) tick();
    abort3 = 1; tick(); abort3 = 0;           // edge 11
    chk("ab_busy", busy3, 0);
    chk("ab_vld", vld3, 0);
    chk("ab_done", done3, 0);
    chk("ab_vec", vec3, 0);
    chk("ab_tbl", tbl3, 8'h02);
    start3 = 1; tick(); start3 = 0;           // edge 12, restart accepted
    chk("ab_restart", busy3, 1);
    chk("ab_tbl_clr", tbl3, 0);

    // Reset mid-sweep with start held high, sampled at relative edge 21
    for (int e = 1; e <= 20; e++) tick();
    chk("rs_pre_tbl", tbl3, 8'h16);
    rst = 1; start3 = 1; tick();
    chk("rs_busy", busy3, 0);
    chk("rs_vld", vld3, 0);
    chk("rs_done", done3, 0);
    chk("rs_vec", vec3, 0);
    chk("rs_tbl", tbl3, 0);
    rst = 0; start3 = 0; tick();
    chk("rs_idle", busy3, 0);

    // Majority sweep, abort held in IDLE is ignored, stray starts at 5 and 15
    sel_maj = 1;
    start3 = 1; abort3 = 1; tick(); start3 = 0; abort3 = 0;   // edge 0
    chk("mj_busy0", busy3, 1);
    chk("mj_vld0", vld3, 1);
    chk("mj_vec0", vec3, 0);
    ndone = 0;
    prev = vec3;
    for (int e = 1; e <= 34; e++) begin
      start3 = (e == 5) || (e == 15);
      tick();
      start3 = 0;
      if (done3) ndone++;
      if (e < 32) begin
        chk($sformatf("mj_vec_e%0d", e), vec3, seqv(e / 4));
`ifdef BF_SWEEP_GRAY_EN
        if (vec3 != prev) chk("gray_step", $countones(vec3 ^ prev), 1);
`endif
        prev = vec3;
      end
      if (e == 32) begin
        chk("mj_done32", done3, 1);
        chk("mj_busy32", busy3, 0);
        chk("mj_vld32", vld3, 0);
      end
      if (e == 33) chk("mj_done33", done3, 0);
    end
    chk("mj_ndone", ndone, 1);
    chk("mj_tbl", tbl3, 8'hE8);

    // HOLD=1 XOR sweep: vector changes every cycle, done at edge 8
    start1 = 1; tick(); start1 = 0;           // edge 0
    chk("x1_vec0", vec1, 0);
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("x1_vec_e%0d", e), vec1, seqv(e));
    end
    tick();                                   // edge 8
    chk("x1_done8", done1, 1);
    chk("x1_busy8", busy1, 0);
    chk("x1_tbl", tbl1, 8'h96);
    tick();
    chk("x1_done9", done1, 0);

    // N_IN=8: index must not wrap, done at edge 256 with all-ones table
    start8 = 1; tick(); start8 = 0;           // edge 0
    ndone = 0;
    for (int e = 1; e <= 257; e++) begin
      tick();
      if (done8) ndone++;
      if (e == 255) chk("n8_busy255", busy8, 1);
      if (e == 256) chk("n8_done256", done8, 1);
    end
    chk("n8_ndone", ndone, 1);
    chk("n8_tbl", tbl8, {256{1'b1}});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_sweep_gen.md
BF_SWEEP_GEN -- requirements
Module: bf_sweep_gen

Interface
REQ-001 Parameter N_IN, default 3, number of Boolean-function inputs swept; legal range 1..8.
REQ-002 Parameter HOLD, default 4, number of clock cycles each input vector is held; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request a new sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel a sweep in progress; no done pulse.
REQ-007 dut_out  input  1  output of the function under test for the current vector.
REQ-008 vec_out  output  N_IN  input vector driven to the DUT; bit 0 is the fastest-toggling input.
REQ-009 vec_valid  output  1  high while vec_out holds a vector under test.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  one-cycle pulse when a full sweep completes.
REQ-012 table_out  output  2**N_IN  captured truth table; bit i holds dut_out for vector value i.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at edge k SHALL enter RUN, set vec_out=0 and hold count=0, clear table_out, and assert busy and vec_valid from edge k.
REQ-015 In RUN, each vector SHALL be held for exactly HOLD cycles, with the hold count running 0..HOLD-1.
REQ-016 dut_out SHALL be sampled into table_out[vec_out] at the edge where hold count equals HOLD-1.
REQ-017 At that same edge, vec_out SHALL advance to the next vector and hold count SHALL reset to 0.
REQ-018 After the vector with sequence index 2**N_IN-1 is sampled, the FSM SHALL enter DONE at that edge, i.e. at edge k+HOLD*2**N_IN, with done=1, busy=0 and vec_valid=0.
REQ-019 DONE SHALL last one cycle, then return to IDLE; done is therefore a single-cycle pulse.
REQ-020 table_out SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-021 start SHALL be ignored in RUN and DONE.
REQ-022 abort=1 in RUN SHALL force IDLE at the next edge, with vec_out=0, vec_valid=0, busy=0 and no done pulse; table_out keeps its partial contents.
REQ-023 abort SHALL take priority over the capture and advance at the same edge.
REQ-024 abort in IDLE or DONE SHALL have no effect.
REQ-025 The sequence index counter SHALL be N_IN+1 bits wide so the terminal compare does not wrap at N_IN=8.
REQ-026 In IDLE, vec_out SHALL be 0.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, vec_out=0, vec_valid=0, busy=0, done=0, table_out=0, hold count=0 and sequence index=0, regardless of start or abort.
REQ-028 rst asserted mid-sweep SHALL discard the sweep, produce no done pulse and clear the partial table.

Configuration
REQ-029 The macro BF_SWEEP_GRAY_EN SHALL select the sweep order.
REQ-030 With BF_SWEEP_GRAY_EN defined, vec_out SHALL equal idx ^ (idx >> 1), where idx is the sequence index, so exactly one input changes per step; capture stays indexed by the vec_out value.
REQ-031 Without BF_SWEEP_GRAY_EN, vec_out SHALL equal idx (binary order, matching the team's existing A/B/C toggle stimulus pattern).
REQ-032 The final table_out SHALL be identical in both builds for the same DUT.

Structure
REQ-033 Package bf_sweep_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the function to_gray(idx).
REQ-034 Sub-module bf_hold_timer SHALL implement the hold counter, with inputs clk, rst, clr and en, and a 1-bit last output at count HOLD-1.
REQ-035 The HOLD parameter SHALL be passed down to bf_hold_timer.

Verification
REQ-036 N_IN=3, HOLD=4, dut_out=majority(vec_out), start at edge 0 -> done pulse at edge 32, table_out=8'b1110_1000.
REQ-037 N_IN=3, HOLD=1, dut_out=^vec_out (XOR) -> done at edge 8, table_out=8'b1001_0110; vec_out changes every cycle.
REQ-038 Gray build, N_IN=3 -> vec_out sequence 0,1,3,2,6,7,5,4; Hamming distance 1 per step; same table as the binary build.
REQ-039 abort at edge 10 (N_IN=3, HOLD=4) -> IDLE at edge 11, no done, table_out bits 0..1 captured and the rest 0; start at edge 12 is accepted.
REQ-040 rst at edge 20 mid-sweep with start held high -> all outputs 0 at edge 21; start pulses at edges 5 and 15 of a later sweep are ignored, with a single done at edge 32 of that sweep.
REQ-041 N_IN=8, HOLD=1, dut_out=1 -> done at edge 256 with table_out all ones, confirming no index wrap.
